mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sequences PC, IR, register file, ALU, memory port and immediate extender (sign- vs zero-extend select) one instruction at a time.
- Handshakes with a variable-latency unified memory and traps on memory timeout or illegal opcode.
- Sits beside the datapath top, driven by the latched IR fields.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ready_i in any memory state before bus error.
- CNT_W, 5, width of the wait counter; must hold TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- opcode_i  in  6  IR[31:26], stable after IR write.
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current access this cycle.
- pc_we_o  out  1  PC write enable.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_rd_o  out  1  memory read request.
- mem_wr_o  out  1  memory write request.
- ir_we_o  out  1  IR and MDR-bypass write enable.
- reg_we_o  out  1  register file write enable.
- reg_dst_o  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg_o  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b_o  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = ext(imm), 11 = ext(imm)<<2.
- alu_op_o  out  2  ALU op: 00 = add, 01 = sub, 10 = funct field, 11 = opcode immediate op.
- pc_src_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ext_sign_o  out  1  immediate extender mode: 1 = sign-extend, 0 = zero-extend.
- illegal_o  out  1  sticky: unsupported opcode decoded.
- bus_err_o  out  1  sticky: memory timeout.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- State encodings: RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12, HALT=15.
- Reset:
  - rst_i samples high at an edge → next state RESET, wait counter 0, illegal_o=0, bus_err_o=0. This applies in any state, mid-access included.
  - RESET drives all outputs 0 except ext_sign_o=1.
  - RESET → FETCH unconditionally.
- Default outputs are 0 in every state unless listed below.
- FETCH:
  - mem_rd_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=00, pc_src_o=00.
  - ir_we_o and pc_we_o are 1 only in the cycle mem_ready_i=1 (Mealy-qualified).
  - On ready → DECODE; otherwise stay.
- DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=00 (branch target into ALUOut). Dispatch on opcode_i:
  - 000000 → R_EXEC.
  - 100011 / 101011 → MEM_ADDR.
  - 000100 / 000101 → BRANCH.
  - 000010 → JUMP.
  - 001000 / 001010 / 001100 / 001101 → I_EXEC.
  - Anything else → set illegal_o, go to HALT.
- MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_rd_o=1, iord_o=1. Wait for ready → MEM_WB.
- MEM_WB: reg_we_o=1, reg_dst_o=0, mem_to_reg_o=1 → FETCH.
- MEM_WRITE: mem_wr_o=1, iord_o=1. Wait for ready → FETCH.
- R_EXEC: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=10 → R_WB.
- R_WB: reg_we_o=1, reg_dst_o=1 → FETCH.
- I_EXEC: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=11 → I_WB.
- I_WB: reg_we_o=1, reg_dst_o=0, mem_to_reg_o=0 → FETCH.
- BRANCH:
  - alu_src_a_o=1, alu_src_b_o=00, alu_op_o=01, pc_src_o=01.
  - pc_we_o = (beq & zero_i) | (bne & ~zero_i).
  - → FETCH.
- JUMP: pc_src_o=10, pc_we_o=1 → FETCH.
- ext_sign_o: 0 when opcode_i is 001100 or 001101, else 1. Combinational in all states except RESET, where it is forced to 1.
- Wait counter:
  - Clears on entry to FETCH/MEM_READ/MEM_WRITE and whenever mem_ready_i=1.
  - Increments each waiting cycle.
  - Reaching TIMEOUT with mem_ready_i=0 → bus_err_o=1, mem requests drop, go to HALT.
  - mem_ready_i=1 in the same cycle the counter hits TIMEOUT → the access completes; no error.
- HALT: all outputs 0; stays until reset.
- CPI: R/I-type 4, lw 5, sw 4, beq/bne/j 3. Each memory state adds one cycle per wait cycle.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined:
  - Adds output instr_cnt_o [31:0], the count of retired instructions, cleared by rst_i.
  - Increments on the last cycle of each instruction: MEM_WB, MEM_WRITE with ready, R_WB, I_WB, BRANCH, JUMP.
  - Wraps 0xFFFFFFFF → 0.
  - Holds in HALT.
- Undefined: no port, no counter logic.

Test Plan:
- Reset then add (opcode 000000), mem_ready_i always 1 → states 0,1,2,7,8,1; reg_we_o=1 and reg_dst_o=1 in R_WB only.
- lw with mem_ready_i delayed 3 cycles in MEM_READ → MEM_READ held 4 cycles, mem_rd_o=1 and iord_o=1 throughout, reg_we_o pulses once with mem_to_reg_o=1.
- beq with zero_i=1, then bne with zero_i=1 → pc_we_o=1 in BRANCH for beq, 0 for bne; pc_src_o=01 both.
- ori (001101) → ext_sign_o=0 in DECODE/I_EXEC; addi (001000) → ext_sign_o=1; alu_src_b_o=10 in I_EXEC.
- mem_ready_i held 0 in FETCH with TIMEOUT=16 → bus_err_o=1 after 16 wait cycles, state_o=15, mem_rd_o=0; rst_i high for one cycle → state_o=0, bus_err_o=0.
- Opcode 111111 in DECODE → illegal_o=1, HALT. With CTRL_PERF_CNT_EN: 3 instructions retired before the trap → instr_cnt_o=3 and holds.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Moore outputs per state, with FETCH's IR/PC write and BRANCH's PC write qualified by inputs.
// Memory states wait on mem_ready_i and trap to HALT with bus_err_o after TIMEOUT wait cycles.
// Optional retired-instruction counter (instr_cnt_o) enabled by macro CTRL_PERF_CNT_EN.
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_we_o,
  output logic        iord_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        ir_we_o,
  output logic        reg_we_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  pc_src_o,
  output logic        ext_sign_o,
  output logic        illegal_o,
  output logic        bus_err_o,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] instr_cnt_o,
`endif
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StIExec    = 4'd11,
    StIWb      = 4'd12,
    StHalt     = 4'd15
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;

  // Last waiting cycle: one more miss would make TIMEOUT wait cycles.
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic             r_illegal, w_illegal_next;
  logic             r_bus_err, w_bus_err_next;
  logic             w_retire;

  // State, wait counter and sticky trap flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StReset;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_illegal  <= w_illegal_next;
      r_bus_err  <= w_bus_err_next;
    end
  end

  // Memory-state wait handling shared by FETCH, MEM_READ and MEM_WRITE.
  logic w_in_mem_state;
  logic w_timeout;
  always_comb begin
    w_in_mem_state = (r_state == StFetch) || (r_state == StMemRead) ||
                     (r_state == StMemWrite);
    w_timeout      = w_in_mem_state && !mem_ready_i && (r_wait_cnt == TimeoutLast);
    // Counter is zero whenever we are outside a wait, so entry always starts at 0.
    w_wait_cnt_next = '0;
    if (w_in_mem_state && !mem_ready_i && !w_timeout) begin
      w_wait_cnt_next = r_wait_cnt + 1'b1;
    end
  end

  // Next-state logic and per-state control outputs.
  always_comb begin
    w_state_next   = r_state;
    w_illegal_next = r_illegal;
    w_bus_err_next = r_bus_err | w_timeout;
    w_retire       = 1'b0;
    pc_we_o        = 1'b0;
    iord_o         = 1'b0;
    mem_rd_o       = 1'b0;
    mem_wr_o       = 1'b0;
    ir_we_o        = 1'b0;
    reg_we_o       = 1'b0;
    reg_dst_o      = 1'b0;
    mem_to_reg_o   = 1'b0;
    alu_src_a_o    = 1'b0;
    alu_src_b_o    = 2'b00;
    alu_op_o       = 2'b00;
    pc_src_o       = 2'b00;
    ext_sign_o     = !((opcode_i == OpAndi) || (opcode_i == OpOri));

    unique case (r_state)
      StReset: begin
        ext_sign_o   = 1'b1;
        w_state_next = StFetch;
      end
      StFetch: begin
        mem_rd_o    = 1'b1;
        alu_src_b_o = 2'b01;
        ir_we_o     = mem_ready_i;
        pc_we_o     = mem_ready_i;
        if (mem_ready_i)    w_state_next = StDecode;
        else if (w_timeout) w_state_next = StHalt;
      end
      StDecode: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OpRType:                        w_state_next = StRExec;
          OpLw, OpSw:                     w_state_next = StMemAddr;
          OpBeq, OpBne:                   w_state_next = StBranch;
          OpJ:                            w_state_next = StJump;
          OpAddi, OpSlti, OpAndi, OpOri:  w_state_next = StIExec;
          default: begin
            w_illegal_next = 1'b1;
            w_state_next   = StHalt;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        w_state_next = (opcode_i == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_rd_o = 1'b1;
        iord_o   = 1'b1;
        if (mem_ready_i)    w_state_next = StMemWb;
        else if (w_timeout) w_state_next = StHalt;
      end
      StMemWb: begin
        reg_we_o     = 1'b1;
        mem_to_reg_o = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StMemWrite: begin
        mem_wr_o = 1'b1;
        iord_o   = 1'b1;
        if (mem_ready_i) begin
          w_retire     = 1'b1;
          w_state_next = StFetch;
        end else if (w_timeout) begin
          w_state_next = StHalt;
        end
      end
      StRExec: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = 2'b10;
        w_state_next = StRWb;
      end
      StRWb: begin
        reg_we_o     = 1'b1;
        reg_dst_o    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StIExec: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        alu_op_o     = 2'b11;
        w_state_next = StIWb;
      end
      StIWb: begin
        reg_we_o     = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StBranch: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = 2'b01;
        pc_src_o     = 2'b01;
        pc_we_o      = ((opcode_i == OpBeq) && zero_i) || ((opcode_i == OpBne) && !zero_i);
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StJump: begin
        pc_src_o     = 2'b10;
        pc_we_o      = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StHalt: begin
        w_state_next = StHalt;
      end
      default: begin
        w_state_next = StHalt;
      end
    endcase
  end

  assign illegal_o = r_illegal;
  assign bus_err_o = r_bus_err;
  assign state_o   = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_instr_cnt;

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i)         r_instr_cnt <= '0;
    else if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
  end

  assign instr_cnt_o = r_instr_cnt;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        ready;
  logic        pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        ext_sign, illegal, bus_err;
  logic [3:0]  state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem_ready_i  (ready),
    .pc_we_o      (pc_we),
    .iord_o       (iord),
    .mem_rd_o     (mem_rd),
    .mem_wr_o     (mem_wr),
    .ir_we_o      (ir_we),
    .reg_we_o     (reg_we),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .pc_src_o     (pc_src),
    .ext_sign_o   (ext_sign),
    .illegal_o    (illegal),
    .bus_err_o    (bus_err),
`ifdef CTRL_PERF_CNT_EN
    .instr_cnt_o  (instr_cnt),
`endif
    .state_o      (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards settle before the #1 checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b000000; zero = 1'b0; ready = 1'b1;
    tick();
    #1;
    check("rst_state", state, 0);
    check("rst_ext_sign", ext_sign, 1);
    check("rst_pc_we", pc_we, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_illegal", illegal, 0);
    check("rst_bus_err", bus_err, 0);
    rst = 1'b0;

    // add: 0,1,2,7,8,1
    tick(); #1;
    check("add_fetch_state", state, 1);
    check("add_fetch_mem_rd", mem_rd, 1);
    check("add_fetch_iord", iord, 0);
    check("add_fetch_srcb", alu_src_b, 2'b01);
    check("add_fetch_ir_we", ir_we, 1);
    check("add_fetch_pc_we", pc_we, 1);
    check("add_fetch_reg_we", reg_we, 0);
    tick(); #1;
    check("add_decode_state", state, 2);
    check("add_decode_srcb", alu_src_b, 2'b11);
    check("add_decode_reg_we", reg_we, 0);
    tick(); #1;
    check("add_rexec_state", state, 7);
    check("add_rexec_aluop", alu_op, 2'b10);
    check("add_rexec_srca", alu_src_a, 1);
    check("add_rexec_reg_we", reg_we, 0);
    tick(); #1;
    check("add_rwb_state", state, 8);
    check("add_rwb_reg_we", reg_we, 1);
    check("add_rwb_reg_dst", reg_dst, 1);
    tick(); #1;
    check("add_back_fetch", state, 1);

    // lw with three not-ready cycles in MEM_READ
    opcode = 6'b100011;
    tick(); #1;
    check("lw_decode", state, 2);
    tick(); #1;
    check("lw_memaddr", state, 3);
    check("lw_memaddr_srcb", alu_src_b, 2'b10);
    check("lw_memaddr_srca", alu_src_a, 1);
    ready = 1'b0;
    tick(); #1;
    for (int i = 0; i < 3; i++) begin
      check("lw_memread_wait_state", state, 4);
      check("lw_memread_wait_rd", mem_rd, 1);
      check("lw_memread_wait_iord", iord, 1);
      check("lw_memread_wait_reg_we", reg_we, 0);
      tick(); #1;
    end
    ready = 1'b1; #1;
    check("lw_memread_last_state", state, 4);
    check("lw_memread_last_rd", mem_rd, 1);
    check("lw_memread_last_iord", iord, 1);
    tick(); #1;
    check("lw_memwb_state", state, 5);
    check("lw_memwb_reg_we", reg_we, 1);
    check("lw_memwb_m2r", mem_to_reg, 1);
    check("lw_memwb_reg_dst", reg_dst, 0);
    tick(); #1;
    check("lw_back_fetch", state, 1);
    check("lw_fetch_reg_we", reg_we, 0);

    // beq taken, zero=1
    opcode = 6'b000100; zero = 1'b1;
    tick(); tick(); #1;
    check("beq_state", state, 9);
    check("beq_pc_we", pc_we, 1);
    check("beq_pc_src", pc_src, 2'b01);
    check("beq_aluop", alu_op, 2'b01);
    tick(); #1;
    check("beq_back_fetch", state, 1);

    // bne not taken, zero=1
    opcode = 6'b000101;
    tick(); tick(); #1;
    check("bne_state", state, 9);
    check("bne_pc_we", pc_we, 0);
    check("bne_pc_src", pc_src, 2'b01);
    tick();

    // ori: zero-extend
    opcode = 6'b001101;
    tick(); #1;
    check("ori_decode_state", state, 2);
    check("ori_decode_ext", ext_sign, 0);
    tick(); #1;
    check("ori_iexec_state", state, 11);
    check("ori_iexec_ext", ext_sign, 0);
    check("ori_iexec_srcb", alu_src_b, 2'b10);
    check("ori_iexec_aluop", alu_op, 2'b11);
    tick(); #1;
    check("ori_iwb_state", state, 12);
    check("ori_iwb_reg_we", reg_we, 1);
    check("ori_iwb_m2r", mem_to_reg, 0);
    check("ori_iwb_reg_dst", reg_dst, 0);
    tick();

    // addi: sign-extend
    opcode = 6'b001000;
    tick(); #1;
    check("addi_decode_ext", ext_sign, 1);
    tick(); #1;
    check("addi_iexec_state", state, 11);
    check("addi_iexec_ext", ext_sign, 1);
    check("addi_iexec_srcb", alu_src_b, 2'b10);
    tick(); tick();

    // sw, then j
    opcode = 6'b101011;
    tick(); tick(); tick(); #1;
    check("sw_memwrite_state", state, 6);
    check("sw_memwrite_wr", mem_wr, 1);
    check("sw_memwrite_iord", iord, 1);
    check("sw_memwrite_rd", mem_rd, 0);
    tick(); #1;
    check("sw_back_fetch", state, 1);
    opcode = 6'b000010;
    tick(); tick(); #1;
    check("j_state", state, 10);
    check("j_pc_we", pc_we, 1);
    check("j_pc_src", pc_src, 2'b10);
    tick(); #1;
    check("j_back_fetch", state, 1);

    // FETCH timeout: 16 wait cycles then HALT
    ready = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      check("to_wait_state", state, 1);
      check("to_wait_bus_err", bus_err, 0);
      check("to_wait_ir_we", ir_we, 0);
      tick();
    end
    #1;
    check("to_halt_state", state, 15);
    check("to_halt_bus_err", bus_err, 1);
    check("to_halt_mem_rd", mem_rd, 0);
    check("to_halt_pc_we", pc_we, 0);
    ready = 1'b1;
    tick(); #1;
    check("to_halt_stays", state, 15);
    check("to_halt_sticky", bus_err, 1);
    rst = 1'b1;
    tick(); #1;
    rst = 1'b0;
    check("to_rst_state", state, 0);
    check("to_rst_bus_err", bus_err, 0);

    // add, beq, j retire, then illegal opcode
    opcode = 6'b000000;
    tick(); tick(); tick(); tick(); tick(); #1;
    check("ill_pre_fetch1", state, 1);
    opcode = 6'b000100; zero = 1'b0;
    tick(); tick(); tick(); #1;
    check("ill_pre_fetch2", state, 1);
    opcode = 6'b000010;
    tick(); tick(); tick(); #1;
    check("ill_pre_fetch3", state, 1);
    opcode = 6'b111111;
    tick(); #1;
    check("ill_decode_state", state, 2);
    check("ill_decode_flag", illegal, 0);
    tick(); #1;
    check("ill_halt_state", state, 15);
    check("ill_halt_flag", illegal, 1);
    check("ill_halt_bus_err", bus_err, 0);
`ifdef CTRL_PERF_CNT_EN
    check("ill_instr_cnt", instr_cnt, 3);
`endif
    tick(); tick(); #1;
    check("ill_halt_hold", state, 15);
    check("ill_flag_hold", illegal, 1);
`ifdef CTRL_PERF_CNT_EN
    check("ill_instr_cnt_hold", instr_cnt, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
